fifo_ctrl_v2: RTL

Parametrised synchronous FIFO, successor to the debug module's single-width FIFO. Adds a data-width parameter, optional first-word fall-through, programmable almost-full/almost-empty thresholds, fill-level output, push-while-full-with-pop acceptance, and overflow/underflow indication. Used for DMI request/response buffering and abstract-command queues inside the debug module. Single clock, no clock-domain crossing.

---
 rtl/fifo_ctrl_v2.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl_v2.sv
// fifo_ctrl_v2 -- parametrised single-clock FIFO with optional fall-through,
// almost-full/empty thresholds, fill level and overflow/underflow pulses. Rev 1.0
`default_nettype none

module fifo_ctrl_v2 #(
    parameter int DEPTH        = 8,
    parameter int DWIDTH       = 32,
    parameter int FALL_THROUGH = 0,
    parameter int AF_LEVEL     = DEPTH - 1,
    parameter int AE_LEVEL     = 1,
    localparam int AW          = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AW:0]       usage_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam bit            FT       = (FALL_THROUGH != 0);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       cnt;
    logic [31:0]       cnt_wide;

    logic is_empty;
    logic is_full;
    logic push_ok;
    logic pop_ok;
    logic passthru;
    logic advance;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);
    assign cnt_wide = 32'(cnt);

    assign pop_ok   = pop_i & (~is_empty | (FT & push_i));
    assign push_ok  = push_i & (~is_full | pop_i);
    // Empty fall-through FIFO with simultaneous push/pop hands data straight across.
    assign passthru = FT & is_empty & push_i & pop_i;
    assign advance  = ~flush_i & ~passthru;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (advance && push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (advance) begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign data_o         = (is_empty && FT) ? data_i : mem[rd_ptr];
    assign full_o         = is_full;
    assign empty_o        = is_empty;
    assign usage_o        = cnt;
    assign almost_full_o  = (cnt_wide >= $unsigned(AF_LEVEL));
    assign almost_empty_o = (cnt_wide <= $unsigned(AE_LEVEL));
    // A flush discards the push outright, so it is not reported as an overflow.
    assign overflow_o     = push_i & ~push_ok & ~flush_i;
    assign underflow_o    = pop_i & ~pop_ok;

endmodule

`default_nettype wire
